// File: rtl/reg_file_sb.sv
// DW x 2**AW register file: two combinational read ports with write bypass, one write port,
// per-register pending bits, and a sweep-clear FSM that zeroes every entry after reset or on request.
module reg_file_sb #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  input  logic          pend_set,
  input  logic [AW-1:0] pend_addr,
  output logic          pendA,
  output logic          pendB,
  output logic          hazard
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [DEPTH-1:0] r_pend;
  logic [DW-1:0]   r_core [DEPTH];

  logic w_busy;
  logic w_wr_ok;
  logic w_pend_ok;
  logic w_clr_go;
  logic w_byp_a;
  logic w_byp_b;

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_wr_ok   = !w_busy && wr_en && !(ZERO_R0 && (wr_addr == '0));
  assign w_pend_ok = !w_busy && pend_set && !(ZERO_R0 && (pend_addr == '0));
  assign w_clr_go  = !w_busy && clr_req;

  // Forwarding only ever fires for a write that will actually land.
  assign w_byp_a = BYPASS && w_wr_ok && (wr_addr == rd_addrA);
  assign w_byp_b = BYPASS && w_wr_ok && (wr_addr == rd_addrB);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A set and a write to the same register in one cycle leave it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (w_clr_go) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pend_ok && (pend_addr == AW'(i))) begin
          r_pend[i] <= 1'b1;
        end else if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // NOTE: the array is deliberately left out of reset; the sweep zeroes it before any read is exposed.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_core[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_core[wr_addr] <= dat_in;
    end
  end

  always_comb begin
    datA_out = '0;
    datB_out = '0;
    pendA    = 1'b0;
    pendB    = 1'b0;
    if (!w_busy) begin
      if (!(ZERO_R0 && (rd_addrA == '0))) datA_out = w_byp_a ? dat_in : r_core[rd_addrA];
      if (!(ZERO_R0 && (rd_addrB == '0))) datB_out = w_byp_b ? dat_in : r_core[rd_addrB];
      pendA = !w_byp_a && r_pend[rd_addrA];
      pendB = !w_byp_b && r_pend[rd_addrB];
    end
  end

  assign busy   = w_busy;
  assign hazard = w_busy | pendA | pendB;

endmodule
